// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Bundles the board-test side and the display side of the four-digit
// seven-segment scan driver.
//   load       : single-cycle strobe, capture value into the pending register
//   value      : four hex nibbles, nibble i drives digit i
//   seg_n      : segments a..g on bits 0..6, active-low
//   dig_n      : digit enables, active-low, bit i selects digit i
//   pend       : a loaded value is waiting for the next frame boundary
//   frame_done : one-cycle pulse when digit 3's lit phase ends
// Modports: master = board-test logic, slave = the scan driver.
interface seg7_scan_driver_if;
  logic        load;
  logic [15:0] value;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        pend;
  logic        frame_done;

  modport master (
    output load,
    output value,
    input  seg_n,
    input  dig_n,
    input  pend,
    input  frame_done
  );

  modport slave (
    input  load,
    input  value,
    output seg_n,
    output dig_n,
    output pend,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes a four-digit common-anode seven-segment display. Each
// digit is preceded by a dark gap (BLANK) to avoid ghosting and then lit
// (SHOW). New values are staged in a pending register and only copied to
// the displayed register at the frame boundary (end of digit 3's SHOW), so
// a frame never shows a mix of old and new digits.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : seg7_scan_driver_if.slave (load/value in, seg_n/dig_n/pend/
//           frame_done out, all outputs registered)
// Parameters:
//   SCAN_DIV  : cycles each digit is lit (>= 2)
//   BLANK_CYC : dark cycles between digits (>= 1)
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, digits above digit 0 whose nibble and all higher nibbles
//   are zero stay dark during SHOW (digit enables still sequence).
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  // The BLANK phase compares against BLANK_CYC itself, so the timer must be
  // able to hold that value even when it is a power of two.
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] SHOW_LAST  = TMR_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYC);
  localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Active-low segment pattern for one hex nibble (bit 6 = g, bit 0 = a).
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  state_t           state_r,      state_nxt_s;
  logic [1:0]       idx_r,        idx_nxt_s;
  logic [TMR_W-1:0] tmr_r,        tmr_nxt_s;
  logic [15:0]      disp_r,       disp_nxt_s;
  logic [15:0]      pending_r,    pending_nxt_s;
  logic             pend_r,       pend_nxt_s;
  logic             frame_done_r;
  logic [3:0]       dig_n_r,      dig_n_nxt_s;
  logic [6:0]       seg_n_r,      seg_n_nxt_s;
  logic             boundary_s;
  logic [15:0]      disp_shift_s;
  logic             lead_blank_s;

  // Phase sequencing: BLANK/SHOW alternation, digit index and phase timer.
  // SHOW->BLANK reloads the timer with 1 so the gap is BLANK_CYC cycles; the
  // reset value 0 adds one cycle so digit 0 lights on post-reset edge
  // BLANK_CYC.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    tmr_nxt_s   = tmr_r + TMR_ONE;
    boundary_s  = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (tmr_r == BLANK_LAST) begin
          state_nxt_s = ST_SHOW;
          tmr_nxt_s   = TMR_ZERO;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (tmr_r == SHOW_LAST) begin
          state_nxt_s = ST_BLANK;
          tmr_nxt_s   = TMR_ONE;
          idx_nxt_s   = idx_r + 2'd1;
          boundary_s  = (idx_r == 2'd3);
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        idx_nxt_s   = 2'd0;
        tmr_nxt_s   = TMR_ZERO;
      end
    endcase
  end

  // Value staging: loads go to pending; pending moves to disp at the frame
  // boundary. A load on the boundary cycle lands in pending after the old
  // pending has been promoted, so pend stays set.
  always_comb begin
    disp_nxt_s    = disp_r;
    pending_nxt_s = pending_r;
    pend_nxt_s    = pend_r;
    if (boundary_s && pend_r) begin
      disp_nxt_s = pending_r;
      pend_nxt_s = 1'b0;
    end else begin
      disp_nxt_s = disp_r;
    end
    if (bus.load) begin
      pending_nxt_s = bus.value;
      pend_nxt_s    = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Output pattern for the cycle after this edge, computed from next state
  // so the registered outputs move on the same edge as the phase change.
  always_comb begin
    disp_shift_s = disp_nxt_s >> {idx_nxt_s, 2'b00};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lead_blank_s = (idx_nxt_s != 2'd0) && (disp_shift_s == 16'h0000);
`else
    lead_blank_s = 1'b0;
`endif
    if (state_nxt_s == ST_SHOW) begin
      dig_n_nxt_s = ~(4'b0001 << idx_nxt_s);
      if (lead_blank_s) begin
        seg_n_nxt_s = 7'h7F;
      end else begin
        seg_n_nxt_s = seg_decode(disp_shift_s[3:0]);
      end
    end else begin
      dig_n_nxt_s = 4'hF;
      seg_n_nxt_s = 7'h7F;
    end
  end

  // State, data and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_BLANK;
      idx_r        <= 2'd0;
      tmr_r        <= TMR_ZERO;
      disp_r       <= 16'h0000;
      pending_r    <= 16'h0000;
      pend_r       <= 1'b0;
      frame_done_r <= 1'b0;
      dig_n_r      <= 4'hF;
      seg_n_r      <= 7'h7F;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      tmr_r        <= tmr_nxt_s;
      disp_r       <= disp_nxt_s;
      pending_r    <= pending_nxt_s;
      pend_r       <= pend_nxt_s;
      frame_done_r <= boundary_s;
      dig_n_r      <= dig_n_nxt_s;
      seg_n_r      <= seg_n_nxt_s;
    end
  end

  assign bus.seg_n      = seg_n_r;
  assign bus.dig_n      = dig_n_r;
  assign bus.pend       = pend_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=2
// (24-cycle frame). Expected outputs come from a timeline model: the cycle
// number since reset release gives the digit slot and phase, and a small
// disp/pending/pend model is updated at each edge from the load rules.
// Build with SEG7_LEADING_ZERO_BLANK_EN to check the leading-zero option.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
  localparam int DIGIT_CYC = SCAN_DIV + BLANK_CYC;
  localparam int FRAME_CYC = 4 * DIGIT_CYC;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic reset;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // model state
  int          cyc;       // index of the last post-reset edge, -1 before edge 0
  logic [15:0] m_disp;
  logic [15:0] m_pending;
  logic        m_pend;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_fd;
    logic [3:0] nib;
    int         o;
    int         k;
    exp_dig = 4'hF;
    exp_seg = 7'h7F;
    exp_fd  = 1'b0;
    if (cyc >= 0) begin
      o      = cyc % DIGIT_CYC;
      k      = (cyc / DIGIT_CYC) % 4;
      exp_fd = (cyc > 0) && (cyc % FRAME_CYC == 0);
      if (o >= BLANK_CYC) begin
        exp_dig    = 4'hF;
        exp_dig[k] = 1'b0;
        nib        = m_disp[4*k +: 4];
        exp_seg    = SEG_TAB[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k > 0 && (m_disp >> (4*k)) == 16'h0000) exp_seg = 7'h7F;
`endif
      end
    end
    check("dig_n",      {12'h000, bus.dig_n},      {12'h000, exp_dig});
    check("seg_n",      {9'h000,  bus.seg_n},      {9'h000,  exp_seg});
    check("frame_done", {15'h0000, bus.frame_done}, {15'h0000, exp_fd});
    check("pend",       {15'h0000, bus.pend},       {15'h0000, m_pend});
  endtask

  // one clock: drive inputs, take the edge, update model, check
  task automatic step(input logic ld, input logic [15:0] val);
    bus.load  = ld;
    bus.value = val;
    @(posedge clk);
    cyc++;
    if (cyc > 0 && cyc % FRAME_CYC == 0 && m_pend) begin
      m_disp = m_pending;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_pending = val;
      m_pend    = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  // idle until the next edge has frame position pos
  task automatic advance_to(input int pos);
    for (int i = 0; i < FRAME_CYC && ((cyc + 1) % FRAME_CYC) != pos; i++) step(1'b0, 16'h0000);
  endtask

  // assert reset between edges, check the asynchronous dark state, release
  task automatic apply_reset();
    bus.load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc       = -1;
    m_disp    = 16'h0000;
    m_pending = 16'h0000;
    m_pend    = 1'b0;
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    logic        rl;
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    cyc       = -1;
    m_disp    = 16'h0000;
    m_pending = 16'h0000;
    m_pend    = 1'b0;
    #2;
    apply_reset();

    // power-up frame: zeros on every digit
    idle(30);

    // scan order with 1234
    step(1'b1, 16'h1234);
    idle(56);

    // no tearing: load while digit 1 is lit
    advance_to(9);
    step(1'b1, 16'hFFFF);
    idle(40);

    // last load wins
    advance_to(3);
    step(1'b1, 16'hAAAA);
    idle(5);
    step(1'b1, 16'hBBBB);
    idle(50);

    // load on the boundary cycle with a value already pending
    advance_to(5);
    step(1'b1, 16'h0E00);
    advance_to(0);
    step(1'b1, 16'h00C0);
    check("pend_after_simultaneous", {15'h0000, bus.pend}, 16'h0001);
    idle(50);

    // leading zeros
    advance_to(1);
    step(1'b1, 16'h0070);
    idle(50);

    // random loads, values often with leading zero nibbles
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(0, 11) == 0);
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      step(rl, rv);
    end

    // reset in the middle of a lit digit with a value pending
    step(1'b1, 16'h5A5A);
    advance_to(15);
    step(1'b0, 16'h0000);
    apply_reset();
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
